instruction_fetch_stage: RTL
============================

Name: instruction_fetch_stage

Overview:
- Parametrised successor to the single-cycle instruction fetch block.
- Contains the PC register, a synchronous-read instruction memory with a loader write port, and the IF/ID output register with a valid bit.
- Adds stall, bubble-insert (flush), PC wrap-around and a memory write path, none of which the previous fetch block had.
- Feeds the decode stage; redirect comes from the branch/jump resolution logic.

Parameters:
- ADDR_WIDTH, 10, word-address width of PC and instruction memory.
- DATA_WIDTH, 32, instruction width.
- MEM_DEPTH, 1024, memory words; must be at most 2^ADDR_WIDTH.
- NOP_WORD, 32'h0000_0000, word loaded into instruc_reg on reset or bubble.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- PC_sel  in  1  1 = redirect: PC loads jump_address; 0 = sequential fetch.
- jump_address  in  ADDR_WIDTH  redirect target (word address).
- stall  in  1  hold PC and IF/ID register.
- flush  in  1  insert bubble into IF/ID; hold PC.
- imem_we  in  1  loader write enable.
- imem_waddr  in  ADDR_WIDTH  loader write address.
- imem_wdata  in  DATA_WIDTH  loader write data.
- instruc_reg  out  DATA_WIDTH  fetched instruction (IF/ID).
- PC_out  out  ADDR_WIDTH  address of the instruction in instruc_reg.
- PC_plus_1  out  ADDR_WIDTH  PC_out+1, modulo 2^ADDR_WIDTH.
- instr_valid  out  1  instruc_reg holds a real instruction.

Behaviour:
- Reset, taking priority over everything:
  - PC_out=0, PC_plus_1=0.
  - instruc_reg=NOP_WORD, instr_valid=0.
  - Memory contents are not cleared.
- Next-PC selection, in priority order:
  - reset: 0.
  - PC_sel=1: jump_address.
  - stall=1 or flush=1: PC_out (hold).
  - Otherwise, after reset: if instr_valid=0, PC_out (first fetch targets address 0); else PC_out+1.
- Memory read address is pc_next, read synchronously. On each non-reset edge, if the IF/ID register loads, then PC_out<=pc_next, instruc_reg<=mem[pc_next] and instr_valid<=1.
- Instruction and address are therefore always aligned: instruc_reg is mem[PC_out] as of the read edge.
- IF/ID update, in priority order:
  - reset.
  - PC_sel=1: load target; overrides stall and flush.
  - flush=1: instruc_reg<=NOP_WORD, instr_valid<=0, PC_out held. Flush has priority over stall.
  - stall=1: hold all outputs.
  - Otherwise: load.
- Latency:
  - First valid instruction (mem[0], PC_out=0) appears after the first rising edge with reset low.
  - A redirect asserted in cycle N gives instruc_reg=mem[jump_address] after edge N. Zero extra bubbles inside this block.
- Arithmetic:
  - PC_plus_1 is combinational from PC_out, ADDR_WIDTH bits.
  - PC all-ones wraps to 0, with no flag.
- Out-of-range addresses: if MEM_DEPTH < 2^ADDR_WIDTH, reads at or above MEM_DEPTH return NOP_WORD.
- Loader write:
  - Takes effect at the edge; independent of stall and flush; also permitted during reset.
  - A write and a read of the same address on the same edge returns the old data (read-first).
  - A write at or above MEM_DEPTH is ignored.
- Flush followed by normal operation: after the bubble, the next load refetches the held PC, so no instruction is lost. The valid-0 rule in next-PC selection applies, so the held PC is not incremented past.
- Reset asserted mid-stall or mid-flush returns all outputs to their reset values at that edge.

Test Plan:
1. Preload mem[0..3]=A0..A3, pulse reset 2 cycles, then run 4 cycles → (PC_out, instruc_reg) = (0,A0),(1,A1),(2,A2),(3,A3); PC_plus_1=1,2,3,4; instr_valid=1 from the first edge after reset.
2. At PC_out=2, assert PC_sel=1 with jump_address=10'h200 and mem[0x200]=B → next edge PC_out=0x200, instruc_reg=B; following edge PC_out=0x201.
3. Stall 3 cycles at PC_out=5 → outputs constant 3 cycles; first release edge gives PC_out=6. Stall and PC_sel together → redirect taken.
4. Flush 1 cycle at PC_out=7 → instruc_reg=0, instr_valid=0, PC_out=7; next edge PC_out=7, instruc_reg=mem[7], valid=1; then 8.
5. Redirect to 0x3FF → PC_out=0x3FF, PC_plus_1=0; next edge PC_out=0, instruc_reg=mem[0].
6. Loader writes C to address 4 on the same edge that PC_out becomes 4 → instruc_reg shows the old mem[4]; a later redirect to 4 shows C. Reset mid-stream → PC_out=0, valid=0, instruc_reg=0.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, synchronous-read instruction memory
// with a loader write port, and the IF/ID register with stall, flush and redirect.
module instruction_fetch_stage #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_DEPTH  = 1024,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  PC_sel,
    input  logic [ADDR_WIDTH-1:0] jump_address,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  imem_we,
    input  logic [ADDR_WIDTH-1:0] imem_waddr,
    input  logic [DATA_WIDTH-1:0] imem_wdata,
    output logic [DATA_WIDTH-1:0] instruc_reg,
    output logic [ADDR_WIDTH-1:0] PC_out,
    output logic [ADDR_WIDTH-1:0] PC_plus_1,
    output logic                  instr_valid
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  ifid_load;
    logic                  rd_in_range;
    logic                  wr_in_range;
    logic                  pc_live;

    // Range checks only exist when the memory is smaller than the address space.
    generate
        if (MEM_DEPTH < (2 ** ADDR_WIDTH)) begin : g_partial
            localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);
            assign rd_in_range = (pc_next    < DEPTH_A);
            assign wr_in_range = (imem_waddr < DEPTH_A);
        end else begin : g_full
            assign rd_in_range = 1'b1;
            assign wr_in_range = 1'b1;
        end
    endgenerate

    // A cleared valid bit means the held PC has not been delivered yet, so refetch it.
    always_comb begin
        pc_next   = PC_out;
        ifid_load = 1'b0;
        if (PC_sel) begin
            pc_next   = jump_address;
            ifid_load = 1'b1;
        end else if (stall || flush) begin
            pc_next   = PC_out;
        end else begin
            pc_next   = instr_valid ? (PC_out + 1'b1) : PC_out;
            ifid_load = 1'b1;
        end
    end

    assign PC_plus_1 = pc_live ? (PC_out + 1'b1) : '0;

    always_ff @(posedge clock) begin
        if (imem_we && wr_in_range) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    // Reading mem here sees the pre-edge contents, giving read-first behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            PC_out      <= '0;
            instruc_reg <= NOP_WORD;
            instr_valid <= 1'b0;
            pc_live     <= 1'b0;
        end else if (ifid_load) begin
            PC_out      <= pc_next;
            instruc_reg <= rd_in_range ? mem[pc_next] : NOP_WORD;
            instr_valid <= 1'b1;
            pc_live     <= 1'b1;
        end else if (flush) begin
            instruc_reg <= NOP_WORD;
            instr_valid <= 1'b0;
        end
    end

endmodule
